// File: rtl/minibus_master_lsu.sv
// Minibus master for single-beat CPU loads/stores: checks width/alignment,
// drives one bus request, waits for ack/err/timeout, extends load data.
//
// Ports:
//   clk, nrst            clock, async active-low reset
//   cpu_ren/cpu_wen      level load/store request from the core
//   cpu_addr/cpu_wdata   byte address, right-aligned store data
//   cpu_funct3           RV32 access size/signedness
//   cpu_rdata            extended load result (updated on load ack)
//   cpu_done/cpu_err     one-cycle completion pulse and fault flag
//   cpu_busy             transaction in progress
//   bus_addr/bus_wdata   request address/data (held outside BUSY)
//   bus_width            funct3 of the request, [1:0] = size
//   bus_ren/bus_wen      request strobes, BUSY only
//   bus_rdata/ack/err    slave response
module minibus_master_lsu #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cpu_ren,
  input  logic                 cpu_wen,
  input  logic [BIT_WIDTH-1:0] cpu_addr,
  input  logic [BIT_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]           cpu_funct3,
  output logic [BIT_WIDTH-1:0] cpu_rdata,
  output logic                 cpu_done,
  output logic                 cpu_err,
  output logic                 cpu_busy,
  output logic [BIT_WIDTH-1:0] bus_addr,
  output logic [BIT_WIDTH-1:0] bus_wdata,
  output logic [2:0]           bus_width,
  output logic                 bus_ren,
  output logic                 bus_wen,
  input  logic [BIT_WIDTH-1:0] bus_rdata,
  input  logic                 bus_ack,
  input  logic                 bus_err
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_M1 =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q, wdata_q;
  logic [2:0]           f3_q;
  logic                 ren_q, wen_q, err_q, err_d;
  logic [CW-1:0]        cnt_q;
  logic [BIT_WIDTH-1:0] rdata_d, ext;
  logic                 req, legal, latch;
  logic                 bad_f3, misalign, timeout;

  assign req = cpu_ren | cpu_wen;

  assign bad_f3 = (cpu_funct3 == 3'b011) ||
                  (cpu_funct3[2:1] == 2'b11);

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      (cpu_funct3[1:0] == 2'b01): misalign = cpu_addr[0];
      (cpu_funct3[1:0] == 2'b10): misalign = |cpu_addr[1:0];
      default:                    misalign = 1'b0;
    endcase
  end

  assign legal = !(cpu_ren && cpu_wen) && !bad_f3 &&
                 !(cpu_wen && cpu_funct3[2]) && !misalign;

  // Counter holds the number of BUSY cycles already elapsed.
  assign timeout = TO_EN && (cnt_q == CW'(TO_M1));

  always_comb begin
    ext = bus_rdata;
    unique case (f3_q)
      3'b000: ext = {{(BIT_WIDTH-8){bus_rdata[7]}},
                     bus_rdata[7:0]};
      3'b100: ext = {{(BIT_WIDTH-8){1'b0}},
                     bus_rdata[7:0]};
      3'b001: ext = {{(BIT_WIDTH-16){bus_rdata[15]}},
                     bus_rdata[15:0]};
      3'b101: ext = {{(BIT_WIDTH-16){1'b0}},
                     bus_rdata[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = cpu_rdata;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          latch   = 1'b1;
          state_d = legal ? BUSY : DONE;
          err_d   = !legal;
        end
      end
      BUSY: begin
        if (bus_err) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (bus_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (ren_q) rdata_d = ext;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      cpu_rdata <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cpu_rdata <= rdata_d;
      if (latch) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        f3_q    <= cpu_funct3;
        ren_q   <= cpu_ren;
        wen_q   <= cpu_wen;
      end
      if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      else                 cnt_q <= '0;
    end
  end

  // Strobes decode from state so reset drops them at once.
  assign bus_ren   = (state_q == BUSY) && ren_q;
  assign bus_wen   = (state_q == BUSY) && wen_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_width = f3_q;

  assign cpu_busy = (state_q != IDLE);
  assign cpu_done = (state_q == DONE);
  assign cpu_err  = (state_q == DONE) && err_q;

endmodule

// File: doc/minibus_master_lsu.md
Name: minibus_master_lsu

Overview:
- Minibus master that turns single-beat CPU data-memory load/store requests into minibus transactions.
- Sits between the core's load/store stage and the minibus address decoder. The decoder generates each slave's sel; this block never drives sel.
- Holds each request on the bus until the slave returns ack or err, or until a watchdog times out.
- Validates width and alignment before any bus access. Sign- or zero-extends load data back to the core.

Parameters:
- BIT_WIDTH, 32, address/data width.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before a bus error is forced; 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- cpu_ren  input  1  load request (level)
- cpu_wen  input  1  store request (level)
- cpu_addr  input  BIT_WIDTH  byte address
- cpu_wdata  input  BIT_WIDTH  store data, right-aligned
- cpu_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cpu_rdata  output  BIT_WIDTH  extended load result
- cpu_done  output  1  one-cycle completion pulse
- cpu_err  output  1  valid with cpu_done: access fault
- cpu_busy  output  1  transaction in progress
- bus_addr  output  BIT_WIDTH  minibus req.addr
- bus_wdata  output  BIT_WIDTH  minibus req.wdata, right-aligned (slave does lane shifting)
- bus_width  output  3  minibus req.width; bits [1:0] = size
- bus_ren  output  1  minibus req.ren
- bus_wen  output  1  minibus req.wen
- bus_rdata  input  BIT_WIDTH  minibus res.rdata, right-aligned, upper bits zero
- bus_ack  input  1  minibus res.ack
- bus_err  input  1  minibus res.err

Behaviour:
- Clock and reset: single clock; asynchronous active-low reset on nrst.
- Reset values: state IDLE; all outputs 0; latched request, timeout counter and cpu_rdata 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request (cpu_ren | cpu_wen):
  - Latch addr, wdata and funct3.
  - Legality check:
    - illegal if cpu_ren & cpu_wen;
    - illegal if funct3 is 011, 110 or 111;
    - illegal if a store has funct3[2]=1;
    - illegal if a halfword has addr[0]=1;
    - illegal if a word has addr[1:0]≠0.
  - Legal request: go to BUSY. Illegal request: go to DONE with err=1; no bus signal asserts.
- BUSY:
  - bus_ren/bus_wen are driven from the latched request. bus_addr, bus_wdata and bus_width are stable for the whole state.
  - bus_ack: capture load data, go to DONE, err=0.
  - bus_err (takes priority over ack): go to DONE, err=1, cpu_rdata unchanged.
  - Watchdog: counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no ack/err, go to DONE with err=1.
- DONE:
  - cpu_done=1 and cpu_err=err for exactly one cycle, then IDLE.
  - bus_ren/bus_wen are 0 here. The request drops the cycle after ack, so a toggling-ready slave does not re-acknowledge.
- Output and request rules:
  - bus_addr/bus_wdata/bus_width hold their last values outside BUSY.
  - cpu_busy = (state ≠ IDLE).
  - CPU request inputs are ignored in BUSY and DONE. A request still asserted in the IDLE cycle after DONE is accepted as a new transaction.
- Load extension (registered into cpu_rdata on ack):
  - B: sign-extend bus_rdata[7:0]. BU: zero-extend it.
  - H: sign-extend bus_rdata[15:0]. HU: zero-extend it.
  - W: pass through.
  - Stores leave cpu_rdata unchanged.
- Latency: the accept edge leads to BUSY the next cycle. With an ack after N BUSY cycles, cpu_done is asserted N+1 cycles after the accept cycle. For the on-chip RAM (ack in the 2nd BUSY cycle), cpu_done comes 3 cycles after accept.
- Reset mid-transaction: return to IDLE immediately. bus_ren/bus_wen drop asynchronously; no cpu_done is produced.

Test Plan:
- LB at 0x1003, bus_rdata=0x00000080, ack in 2nd BUSY cycle -> cpu_done 3 cycles after accept, cpu_err=0, cpu_rdata=0xFFFFFF80; bus_ren high for exactly 2 cycles.
- LHU at 0x2002, bus_rdata=0x0000BEEF -> cpu_rdata=0x0000BEEF. Same access as LH -> cpu_rdata=0xFFFFBEEF.
- SW at 0x3000, wdata=0xDEADBEEF, ack after 1 cycle -> bus_wen=1, bus_width[1:0]=10 and bus_wdata stable in BUSY; cpu_done with err=0; cpu_rdata unchanged.
- LW at 0x3002 (misaligned), then SB with funct3=100 -> no bus_ren/bus_wen assertion; cpu_done and cpu_err=1 on the cycle after accept.
- TIMEOUT_CYCLES=4, LW with ack never asserted -> cpu_done and cpu_err=1 after 4 BUSY cycles; a separate LW with bus_err=1 and bus_ack=1 in the same cycle -> cpu_err=1.
- nrst pulsed low during BUSY -> bus_ren=0 immediately, cpu_busy=0, no cpu_done; a subsequent LW completes normally.
